countdown_seq_32: RTL and testbench
===================================

Name: countdown_seq_32

Overview:
Loadable synchronous down-counter and sequencer, the consumer-side counterpart of the free-running 5-bit up-counter used by multi-cycle processor units (mult/div).
- Initiator loads an iteration count and gets a per-cycle step strobe.
- Block tracks remaining iterations and signals completion through a done/ack handshake.
- Sits between the processor control stage and a multi-cycle datapath; all logic in one clock domain.

Parameters:
- WIDTH, 5, bit width of the count; max load value 2^WIDTH-1 (31 at default).
- ZERO_DONE, 1, when 1 a start with load_val==0 completes immediately; when 0 it is treated as 2^WIDTH iterations.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  load request; sampled only in IDLE.
- load_val  input  WIDTH  iteration count captured on an accepted start.
- hold  input  1  freeze count while in RUN (datapath stall).
- ack  input  1  initiator acknowledges done.
- busy  output  1  high in RUN and DONE.
- step  output  1  one-cycle strobe per decrement; high in RUN when hold==0.
- remaining  output  WIDTH  current remaining count.
- done  output  1  high in DONE until acked.

Behaviour:
- Reset (rst high at posedge) forces state=IDLE, remaining=0, busy=0, step=0, done=0. Reset dominates every other input, including mid-RUN and in DONE.
- States: IDLE, RUN, DONE; 2-bit encoding; outputs decoded from registered state.
- IDLE:
  - start=1 with load_val!=0: remaining<=load_val, next state RUN.
  - start=1 with load_val==0: if ZERO_DONE=1, go to DONE directly; if ZERO_DONE=0, remaining<=0 and go to RUN, giving 2^WIDTH steps via wrap.
  - start=0: stay in IDLE.
- RUN:
  - step = ~hold, combinational from state and hold.
  - Each cycle with hold=0: remaining<=remaining-1 (mod 2^WIDTH).
  - When a decrement takes remaining from 1 to 0, next state is DONE.
  - With hold=1: remaining and state unchanged.
  - start is ignored in RUN.
- DONE: done=1, busy=1, remaining=0.
  - ack=1: next state IDLE.
  - ack and start both high in DONE: ack is honoured; start is ignored, since start is sampled only in IDLE.
- Latency: load_val=N (N>0), hold=0 throughout → exactly N step pulses on cycles 1..N after the start edge; done rises on cycle N+1.
- remaining never underflows except the intentional ZERO_DONE=0 wrap on load.
- All outputs are registered state or pure decode of state plus hold; no combinational path from start or ack to outputs.

Optional Feature:
- Macro: COUNTDOWN_AUTO_RELOAD_EN.
- Defined: adds input reload (1 bit). If reload=1 on the cycle of the final decrement, remaining<=load_val and state stays RUN; done is not asserted, and step continues without a gap.
- Undefined: reload port is absent; behaviour exactly as above.

Decomposition:
- Shared package holds:
  - state enum (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2);
  - default WIDTH constant (5);
  - CNT_MAX localparam derivation.
- One sub-module: countdown_reg, a WIDTH-bit register with sync clear, load, and enabled decrement, plus a zero-next flag output.
- The FSM stays in the top module.

Test Plan:
- Reset mid-RUN: load 10, assert rst after 4 steps → next cycle state IDLE, remaining=0, busy=0, step=0, done=0.
- Basic count: load_val=5, hold=0 → step high 5 consecutive cycles; remaining 5→4→3→2→1→0; done on cycle 6; ack → IDLE one cycle later.
- Hold: load_val=3, hold high for 2 cycles after first step → 3 steps total over 5 cycles; remaining frozen at 2 during hold.
- Zero load: load_val=0 with ZERO_DONE=1 → done next cycle, no step. With ZERO_DONE=0 → exactly 32 steps, then done.
- Start ignored while busy: start pulses during RUN and during DONE-with-ack → count unaffected, no reload; IDLE reached with remaining=0.
- Auto-reload (macro defined): load_val=2, reload=1 on the final step → steps continue uninterrupted; remaining reloads to 2; done stays 0 until a final step with reload=0.

Source files
------------

// File: rtl/countdown_seq_32_pkg.sv
// -----------------------------------------------------------------------------
// countdown_seq_32_pkg
// Shared definitions for the countdown_seq_32 sequencer:
//   - state_e       : sequencer state encoding (IDLE / RUN / DONE, 2 bits)
//   - DEFAULT_WIDTH : default count width (5 bits, loads of 0..31)
//   - cnt_max()     : largest loadable value for a given width
//   - CNT_MAX       : cnt_max() evaluated at the default width
// -----------------------------------------------------------------------------
package countdown_seq_32_pkg;

    localparam int unsigned DEFAULT_WIDTH = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Largest value a WIDTH-bit load can carry.
    function automatic int unsigned cnt_max(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

    localparam int unsigned CNT_MAX = cnt_max(DEFAULT_WIDTH);

endpackage : countdown_seq_32_pkg

// File: rtl/countdown_seq_32_countdown_reg.sv
// -----------------------------------------------------------------------------
// countdown_reg
// WIDTH-bit remaining-iterations register used by countdown_seq_32.
// Priority of operations: reset > clear > load > decrement > hold value.
// Decrement wraps modulo 2^WIDTH; the sequencer relies on this for the
// "load 0 means 2^WIDTH iterations" mode.
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   synchronous reset, active-high (count -> 0)
//   clr_i       in   synchronous clear to 0
//   load_i      in   load load_val_i
//   load_val_i  in   value to load (WIDTH bits)
//   dec_i       in   decrement by one
//   count_o     out  current count (registered)
//   zero_next_o out  count is 1, so the next decrement reaches 0
// -----------------------------------------------------------------------------
module countdown_reg
    import countdown_seq_32_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic [WIDTH-1:0] count_o,
    output logic             zero_next_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o     = count_q;
    assign zero_next_o = (count_q == WIDTH'(1));

endmodule : countdown_reg

// File: rtl/countdown_seq_32.sv
// -----------------------------------------------------------------------------
// countdown_seq_32
// Loadable down-counter / sequencer for multi-cycle datapaths. The initiator
// loads an iteration count, receives one step strobe per iteration, and is
// told of completion through a done/ack handshake.
//
// Parameters:
//   WIDTH     count width; loads 1..2^WIDTH-1 give that many steps
//   ZERO_DONE 1: load of 0 completes at once; 0: load of 0 runs 2^WIDTH steps
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous reset, active-high; dominates all inputs
//   start      in   load request, honoured only in IDLE
//   load_val   in   iteration count captured on an accepted start
//   hold       in   freeze the count while in RUN (datapath stall)
//   ack        in   initiator acknowledges done
//   reload     in   (COUNTDOWN_AUTO_RELOAD_EN only) on the final step,
//                   reload load_val and keep running instead of finishing
//   busy       out  high in RUN and DONE
//   step       out  one strobe per decrement: RUN and hold low
//   remaining  out  iterations still outstanding
//   done       out  high in DONE until acknowledged
//
// Configuration macro: COUNTDOWN_AUTO_RELOAD_EN (adds the reload input).
//
// Outputs depend only on registered state and hold; start and ack never
// reach an output combinationally.
// -----------------------------------------------------------------------------
module countdown_seq_32
    import countdown_seq_32_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned ZERO_DONE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic             hold,
    input  logic             ack,
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    input  logic             reload,
`endif
    output logic             busy,
    output logic             step,
    output logic [WIDTH-1:0] remaining,
    output logic             done
);

    state_e state_q;
    state_e state_d;

    logic cnt_clr;
    logic cnt_load;
    logic cnt_dec;
    logic cnt_zero_next;

    countdown_reg #(
        .WIDTH (WIDTH)
    ) u_countdown_reg (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (cnt_clr),
        .load_i      (cnt_load),
        .load_val_i  (load_val),
        .dec_i       (cnt_dec),
        .count_o     (remaining),
        .zero_next_o (cnt_zero_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (load_val != '0) begin
                        cnt_load = 1'b1;
                        state_d  = ST_RUN;
                    end else if (ZERO_DONE != 0) begin
                        cnt_clr  = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        // Count starts at 0 and wraps on the first decrement,
                        // giving 2^WIDTH steps before reaching 0 again.
                        cnt_clr  = 1'b1;
                        state_d  = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                if (!hold) begin
                    cnt_dec = 1'b1;
                    if (cnt_zero_next) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                        if (reload) begin
                            // Load wins over the decrement inside the register,
                            // so the next step follows without a gap.
                            cnt_load = 1'b1;
                            if ((load_val == '0) && (ZERO_DONE != 0)) begin
                                state_d = ST_DONE;
                            end
                        end else begin
                            state_d = ST_DONE;
                        end
`else
                        state_d = ST_DONE;
`endif
                    end
                end
            end

            ST_DONE: begin
                // start is deliberately not looked at here.
                if (ack) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_clr = 1'b1;
            end
        endcase
    end

    assign busy = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign step = (state_q == ST_RUN) && !hold;
    assign done = (state_q == ST_DONE);

endmodule : countdown_seq_32

// File: tb/tb_countdown_seq_32.sv
module tb_countdown_seq_32;

    localparam int W    = 5;
    localparam int SPAN = 1 << W;

    logic         clk      = 1'b0;
    logic         rst      = 1'b1;
    logic         start    = 1'b0;
    logic         hold     = 1'b0;
    logic         ack      = 1'b0;
    logic [W-1:0] load_val = '0;

    // Instance a: ZERO_DONE=1, instance b: ZERO_DONE=0.
    logic         busy_a, step_a, done_a;
    logic [W-1:0] rem_a;
    logic         busy_b, step_b, done_b;
    logic [W-1:0] rem_b;

    countdown_seq_32 #(.WIDTH(W), .ZERO_DONE(1)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .load_val  (load_val),
        .hold      (hold),
        .ack       (ack),
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        .reload    (1'b0),
`endif
        .busy      (busy_a),
        .step      (step_a),
        .remaining (rem_a),
        .done      (done_a)
    );

    countdown_seq_32 #(.WIDTH(W), .ZERO_DONE(0)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .load_val  (load_val),
        .hold      (hold),
        .ack       (ack),
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        .reload    (1'b0),
`endif
        .busy      (busy_b),
        .step      (step_b),
        .remaining (rem_b),
        .done      (done_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         busy;
        logic         step;
        logic [W-1:0] rem;
        logic         done;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;

    int checks   = 0;
    int failures = 0;

    // Reference model: a job is either absent or present; a present job has
    // some number of steps still to emit, and it is finished (awaiting ack)
    // when that number is zero.
    bit m_active[2];
    int m_left[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t model_out(input int i, input logic h);
        exp_t e;
        e.busy = m_active[i];
        e.done = m_active[i] && (m_left[i] == 0);
        e.step = m_active[i] && (m_left[i] > 0) && !h;
        e.rem  = W'(m_left[i] % SPAN);
        return e;
    endfunction

    task automatic model_update(input int i, input bit zero_done);
        if (rst) begin
            m_active[i] = 1'b0;
            m_left[i]   = 0;
        end else if (!m_active[i]) begin
            if (start) begin
                m_active[i] = 1'b1;
                if (load_val != 0) m_left[i] = int'(load_val);
                else               m_left[i] = zero_done ? 0 : SPAN;
            end
        end else if (m_left[i] > 0) begin
            if (!hold) m_left[i] = m_left[i] - 1;
        end else if (ack) begin
            m_active[i] = 1'b0;
        end
    endtask

    // Apply one cycle of inputs just after the rising edge, queue what both
    // DUTs should show during this cycle, then advance the model across the
    // next edge.
    task automatic drive(input logic s, input logic [W-1:0] lv, input logic h,
                         input logic a, input logic r);
        @(posedge clk);
        #1;
        start    = s;
        load_val = lv;
        hold     = h;
        ack      = a;
        rst      = r;
        q_a.push_back(model_out(0, h));
        q_b.push_back(model_out(1, h));
        model_update(0, 1'b1);
        model_update(1, 1'b0);
    endtask

    task automatic idle_cycles(input int n, input logic a);
        for (int k = 0; k < n; k++) drive(1'b0, '0, 1'b0, a, 1'b0);
    endtask

    // Monitor: compare whatever the DUTs show mid-cycle against the queue.
    always @(negedge clk) begin
        if (q_a.size() > 0) begin
            ea = q_a.pop_front();
            check("zd1.busy",      busy_a, ea.busy);
            check("zd1.step",      step_a, ea.step);
            check("zd1.remaining", rem_a,  ea.rem);
            check("zd1.done",      done_a, ea.done);
        end
        if (q_b.size() > 0) begin
            eb = q_b.pop_front();
            check("zd0.busy",      busy_b, eb.busy);
            check("zd0.step",      step_b, eb.step);
            check("zd0.remaining", rem_b,  eb.rem);
            check("zd0.done",      done_b, eb.done);
        end
    end

    initial begin
        m_active[0] = 1'b0; m_left[0] = 0;
        m_active[1] = 1'b0; m_left[1] = 0;

        // Reset state.
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        idle_cycles(2, 1'b0);

        // Basic count of 5, then acknowledge.
        drive(1'b1, W'(5), 1'b0, 1'b0, 1'b0);
        idle_cycles(7, 1'b0);
        idle_cycles(1, 1'b1);
        idle_cycles(2, 1'b0);

        // Hold for two cycles after the first step.
        drive(1'b1, W'(3), 1'b0, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle_cycles(4, 1'b0);
        idle_cycles(1, 1'b1);
        idle_cycles(1, 1'b0);

        // Zero load: immediate done vs. full wrap of 2^W steps.
        drive(1'b1, '0, 1'b0, 1'b0, 1'b0);
        idle_cycles(3, 1'b0);
        idle_cycles(SPAN + 2, 1'b1);
        idle_cycles(2, 1'b0);

        // start pulses during RUN and together with ack in DONE are ignored.
        drive(1'b1, W'(4), 1'b0, 1'b0, 1'b0);
        drive(1'b1, W'(9), 1'b0, 1'b0, 1'b0);
        drive(1'b1, W'(9), 1'b1, 1'b0, 1'b0);
        idle_cycles(4, 1'b0);
        drive(1'b1, W'(7), 1'b0, 1'b1, 1'b0);
        idle_cycles(SPAN + 2, 1'b1);
        idle_cycles(2, 1'b0);

        // Reset mid-RUN after four steps.
        drive(1'b1, W'(10), 1'b0, 1'b0, 1'b0);
        idle_cycles(4, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        idle_cycles(3, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            logic         s, h, a, r;
            logic [W-1:0] lv;
            s  = ($urandom_range(0, 3) == 0);
            lv = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, SPAN - 1))
                                             : W'($urandom_range(0, 6));
            h  = ($urandom_range(0, 3) == 0);
            a  = ($urandom_range(0, 2) == 0);
            r  = ($urandom_range(0, 149) == 0);
            drive(s, lv, h, a, r);
        end
        idle_cycles(2, 1'b0);

        // Let the monitor drain the last expectations.
        @(negedge clk);
        #1;
        check("scoreboard.zd1_pending", q_a.size(), 0);
        check("scoreboard.zd0_pending", q_b.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_countdown_seq_32
